// File: rtl/trigger_sequencer_pkg.sv
// Shared types for the multi-stage trigger sequencer.
// State encoding and per-bit trigger type constants.
package trigseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic TT_LEVEL = 1'b0;
  localparam logic TT_EDGE  = 1'b1;

endpackage

// File: rtl/trigger_stage_match.sv
// One trigger stage condition check against the current sample.
// Masked-off bits always hold; edge bits need a valid previous sample.
module trigger_stage_match #(
  parameter int size = 32
) (
  input  logic [size-1:0] mask,
  input  logic [size-1:0] ttype,
  input  logic [size-1:0] level,
  input  logic [size-1:0] prev,
  input  logic [size-1:0] din,
  input  logic            prev_valid,
  output logic            match
);

  logic [size-1:0] lvl_ok;
  logic [size-1:0] edge_ok;
  logic [size-1:0] hold;

  assign lvl_ok  = ~(din ^ level);
  assign edge_ok = lvl_ok & (prev ^ din) & {size{prev_valid}};
  assign hold    = (ttype & edge_ok) | (~ttype & lvl_ok);
  assign match   = &(~mask | hold);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer between sample divider and capture writer.
// Walks ordered stage conditions, then counts post-trigger samples.
module trigger_sequencer
  import trigseq_pkg::*;
#(
  parameter int size    = 32,
  parameter int stages  = 8,
  parameter int cnt_w   = 16,
  parameter int saddr_w = 24,
  localparam int NSW    = $clog2(stages + 1),
  localparam int SW     = (stages > 1) ? $clog2(stages) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      sample_en,
  input  logic [size-1:0]           dinput,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [NSW-1:0]            num_stages,
  input  logic [stages*size-1:0]    trig_mask,
  input  logic [stages*size-1:0]    trig_type,
  input  logic [stages*size-1:0]    trig_level,
  input  logic [stages*cnt_w-1:0]   trig_count,
  input  logic [saddr_w-1:0]        post_trigger_count,
  input  logic [saddr_w-1:0]        buffer_size,
  output logic                      armed,
  output logic                      triggered,
  output logic                      done,
  output logic                      ready,
  output logic [SW-1:0]             stage,
  output logic [saddr_w-1:0]        trigger_pos,
  output logic [saddr_w-1:0]        wr_addr,
  output logic                      wr_en
);

  localparam logic [NSW-1:0]     NS_MAX = NSW'(stages);
  localparam logic [NSW-1:0]     NS_ONE = NSW'(1);
  localparam logic [SW-1:0]      SG_ONE = SW'(1);
  localparam logic [cnt_w-1:0]   CW_ONE = cnt_w'(1);
  localparam logic [cnt_w:0]     CX_ONE = (cnt_w + 1)'(1);
  localparam logic [saddr_w-1:0] AD_ONE = saddr_w'(1);

  state_e             state_q, state_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [saddr_w-1:0] ptr_q, ptr_d;
  logic [saddr_w-1:0] waddr_q, waddr_d;
  logic [saddr_w-1:0] tpos_q, tpos_d;
  logic [saddr_w-1:0] rem_q, rem_d;
  logic [size-1:0]    prev_q, prev_d;
  logic               pv_q, pv_d;
  logic               trig_q, trig_d;
  logic               wen_q, wen_d;

  logic [NSW-1:0]     ns_eff;
  logic [size-1:0]    cur_mask, cur_type, cur_level;
  logic [cnt_w-1:0]   cur_cnt, need_cnt;
  logic               cur_match;
  logic               cnt_hit;
  logic               last_stg;
  logic               qual;
  logic               fire;

  assign ns_eff    = (num_stages > NS_MAX) ? NS_MAX : num_stages;
  assign cur_mask  = trig_mask[int'(stage_q)*size +: size];
  assign cur_type  = trig_type[int'(stage_q)*size +: size];
  assign cur_level = trig_level[int'(stage_q)*size +: size];
  assign cur_cnt   = trig_count[int'(stage_q)*cnt_w +: cnt_w];
  assign need_cnt  = (cur_cnt == '0) ? CW_ONE : cur_cnt;
  assign cnt_hit   = ({1'b0, cnt_q} + CX_ONE) >= {1'b0, need_cnt};
  assign last_stg  = (NSW'(stage_q) + NS_ONE) == ns_eff;
  assign qual      = sample_en &
                     ((state_q == ST_RUN) | (state_q == ST_POST));

  trigger_stage_match #(
    .size(size)
  ) u_match (
    .mask      (cur_mask),
    .ttype     (cur_type),
    .level     (cur_level),
    .prev      (prev_q),
    .din       (dinput),
    .prev_valid(pv_q),
    .match     (cur_match)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    tpos_d  = tpos_q;
    rem_d   = rem_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    trig_d  = trig_q;
    wen_d   = 1'b0;
    fire    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      trig_d  = 1'b0;
      stage_d = '0;
    end else if (arm &&
                 (state_q == ST_IDLE || state_q == ST_DONE)) begin
      state_d = ST_RUN;
      ptr_d   = '0;
      waddr_d = '0;
      stage_d = '0;
      cnt_d   = '0;
      pv_d    = 1'b0;
      trig_d  = 1'b0;
    end else if (qual) begin
      wen_d   = 1'b1;
      waddr_d = ptr_q;
      ptr_d   = (ptr_q == buffer_size - AD_ONE) ? '0 : ptr_q + AD_ONE;
      prev_d  = dinput;
      pv_d    = 1'b1;
      if (state_q == ST_RUN) begin
        if (ns_eff == '0) begin
          fire = 1'b1;
        end else if (cur_match) begin
          if (cnt_hit) begin
            cnt_d = '0;
            if (last_stg) fire = 1'b1;
            else stage_d = stage_q + SG_ONE;
          end else begin
            cnt_d = cnt_q + CW_ONE;
          end
        end
        // trigger_pos takes the pre-increment ring index
        if (fire) begin
          trig_d  = 1'b1;
          tpos_d  = ptr_q;
          rem_d   = post_trigger_count;
          state_d = (post_trigger_count == '0) ? ST_DONE : ST_POST;
        end
      end else begin
        rem_d = rem_q - AD_ONE;
        if (rem_q == AD_ONE) state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      tpos_q  <= '0;
      rem_q   <= '0;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      trig_q  <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      tpos_q  <= tpos_d;
      rem_q   <= rem_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      trig_q  <= trig_d;
      wen_q   <= wen_d;
    end
  end

  assign armed       = (state_q == ST_RUN) | (state_q == ST_POST);
  assign done        = (state_q == ST_DONE);
  assign ready       = (state_q == ST_IDLE);
  assign triggered   = trig_q;
  assign stage       = stage_q;
  assign trigger_pos = tpos_q;
  assign wr_addr     = waddr_q;
  assign wr_en       = wen_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Testbench for trigger_sequencer: directed scenarios plus
// randomized runs against a behavioural sequencer model.
module tb_trigger_sequencer;

  localparam int SZ = 32;
  localparam int ST = 8;
  localparam int CW = 16;
  localparam int AW = 24;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_POST = 2;
  localparam int P_DONE = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic           sample_en;
  logic [SZ-1:0]  dinput;
  logic           arm;
  logic           abort;
  logic [3:0]     num_stages;
  logic [ST*SZ-1:0] trig_mask;
  logic [ST*SZ-1:0] trig_type;
  logic [ST*SZ-1:0] trig_level;
  logic [ST*CW-1:0] trig_count;
  logic [AW-1:0]  post_trigger_count;
  logic [AW-1:0]  buffer_size;
  logic           armed;
  logic           triggered;
  logic           done;
  logic           ready;
  logic [2:0]     stage;
  logic [AW-1:0]  trigger_pos;
  logic [AW-1:0]  wr_addr;
  logic           wr_en;

  trigger_sequencer dut (
    .clk               (clk),
    .resetn            (resetn),
    .sample_en         (sample_en),
    .dinput            (dinput),
    .arm               (arm),
    .abort             (abort),
    .num_stages        (num_stages),
    .trig_mask         (trig_mask),
    .trig_type         (trig_type),
    .trig_level        (trig_level),
    .trig_count        (trig_count),
    .post_trigger_count(post_trigger_count),
    .buffer_size       (buffer_size),
    .armed             (armed),
    .triggered         (triggered),
    .done              (done),
    .ready             (ready),
    .stage             (stage),
    .trigger_pos       (trigger_pos),
    .wr_addr           (wr_addr),
    .wr_en             (wr_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] c_mask [ST];
  logic [31:0] c_type [ST];
  logic [31:0] c_level[ST];
  int          c_count[ST];
  int          c_ns, c_ptc, c_bs;

  int          m_ph, m_stage, m_cnt, m_rem;
  longint      m_ptr, m_waddr, m_tpos;
  bit          m_trig, m_wen, m_pv;
  logic [31:0] m_prev;

  logic [55:0] dut_st;
  assign dut_st = {armed, triggered, done, ready, stage,
                   trigger_pos, wr_addr, wr_en};

  function automatic logic [55:0] m_status();
    logic a, d, r;
    a = (m_ph == P_RUN) || (m_ph == P_POST);
    d = (m_ph == P_DONE);
    r = (m_ph == P_IDLE);
    return {a, m_trig, d, r, 3'(m_stage),
            24'(m_tpos), 24'(m_waddr), m_wen};
  endfunction

  function automatic bit m_match(int k, logic [31:0] d);
    for (int b = 0; b < SZ; b++) begin
      if (c_mask[k][b]) begin
        if (d[b] != c_level[k][b]) return 1'b0;
        if (c_type[k][b] && (!m_pv || d[b] == m_prev[b])) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic clear_cfg();
    for (int k = 0; k < ST; k++) begin
      c_mask[k] = '0; c_type[k] = '0; c_level[k] = '0; c_count[k] = 0;
    end
    c_ns = 0; c_ptc = 0; c_bs = 0;
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < ST; k++) begin
      trig_mask[k*SZ +: SZ]  = c_mask[k];
      trig_type[k*SZ +: SZ]  = c_type[k];
      trig_level[k*SZ +: SZ] = c_level[k];
      trig_count[k*CW +: CW] = CW'(c_count[k]);
    end
    num_stages         = 4'(c_ns);
    post_trigger_count = AW'(c_ptc);
    buffer_size        = AW'(c_bs);
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_stage = 0; m_cnt = 0; m_rem = 0;
    m_ptr = 0; m_waddr = 0; m_tpos = 0;
    m_trig = 0; m_wen = 0; m_pv = 0; m_prev = '0;
  endtask

  task automatic model_update(bit se, logic [31:0] d, bit a, bit ab);
    int ns, need;
    longint depth;
    bit fire;
    ns    = (c_ns > ST) ? ST : c_ns;
    depth = (c_bs == 0) ? (64'd1 << AW) : longint'(c_bs);
    m_wen = 0;
    if (ab) begin
      m_ph = P_IDLE; m_trig = 0; m_stage = 0;
    end else if (a && (m_ph == P_IDLE || m_ph == P_DONE)) begin
      m_ph = P_RUN; m_ptr = 0; m_waddr = 0; m_stage = 0;
      m_cnt = 0; m_pv = 0; m_trig = 0;
    end else if (se && (m_ph == P_RUN || m_ph == P_POST)) begin
      m_wen = 1; m_waddr = m_ptr;
      if (m_ph == P_RUN) begin
        fire = 0;
        if (ns == 0) fire = 1;
        else if (m_match(m_stage, d)) begin
          need = (c_count[m_stage] == 0) ? 1 : c_count[m_stage];
          if (m_cnt + 1 >= need) begin
            m_cnt = 0;
            if (m_stage == ns - 1) fire = 1;
            else m_stage++;
          end else m_cnt++;
        end
        if (fire) begin
          m_trig = 1; m_tpos = m_ptr; m_rem = c_ptc;
          m_ph = (c_ptc == 0) ? P_DONE : P_POST;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_ph = P_DONE;
      end
      m_ptr = (m_ptr + 1) % depth;
      m_prev = d; m_pv = 1;
    end
  endtask

  task automatic step(bit se, logic [31:0] d, bit a, bit ab);
    sample_en = se; dinput = d; arm = a; abort = ab;
    @(posedge clk);
    model_update(se, d, a, ab);
    #1;
    sample_en = 0; arm = 0; abort = 0;
  endtask

  task automatic test_reset();
    resetn = 0; sample_en = 0; dinput = '0; arm = 0; abort = 0;
    clear_cfg(); apply_cfg(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_st !== {4'b0001, 3'd0, 24'd0, 24'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", dut_st,
               {4'b0001, 3'd0, 24'd0, 24'd0, 1'b0});
    end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_single_level();
    logic [31:0] seq [3];
    seq = '{32'd0, 32'd0, 32'd1};
    clear_cfg();
    c_ns = 1; c_mask[0] = 1; c_level[0] = 1; c_count[0] = 1; c_ptc = 3;
    apply_cfg();
    step(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, seq[i], 0, 0);
      n_checks++;
      if (dut_st !== m_status()) begin
        n_fail++;
        $display("FAIL single_level[%0d] got %h exp %h", i, dut_st,
                 m_status());
      end
    end
    n_checks++;
    if (triggered !== 1'b1 || trigger_pos !== 24'd2) begin
      n_fail++;
      $display("FAIL single_trigpos got trig=%b pos=%0d exp trig=1 pos=2",
               triggered, trigger_pos);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_two_stage();
    logic [31:0] d;
    clear_cfg();
    c_ns = 2; c_ptc = 2;
    c_mask[0] = 1; c_type[0] = 1; c_level[0] = 1; c_count[0] = 1;
    c_mask[1] = 2; c_level[1] = 2; c_count[1] = 3;
    apply_cfg();
    step(0, '0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      d = {30'd0, (i == 4 || i == 6 || i == 9), (i >= 1)};
      step(1, d, 0, 0);
      n_checks++;
      if (dut_st !== m_status()) begin
        n_fail++;
        $display("FAIL two_stage[%0d] got %h exp %h", i, dut_st,
                 m_status());
      end
      if (i == 1) begin
        n_checks++;
        if (stage !== 3'd1) begin
          n_fail++;
          $display("FAIL two_stage_adv got %0d exp 1", stage);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (triggered !== 1'b0) begin
          n_fail++;
          $display("FAIL two_stage_early got %b exp 0", triggered);
        end
      end
    end
    n_checks++;
    if (triggered !== 1'b1 || trigger_pos !== 24'd9) begin
      n_fail++;
      $display("FAIL two_stage_trig got trig=%b pos=%0d exp trig=1 pos=9",
               triggered, trigger_pos);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_wrap_post();
    int exp_a [5];
    exp_a = '{3, 0, 1, 2, 3};
    clear_cfg();
    c_ns = 1; c_mask[0] = 1; c_level[0] = 1; c_count[0] = 1;
    c_ptc = 5; c_bs = 4;
    apply_cfg();
    step(0, '0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, (i == 6) ? 32'd1 : 32'd0, 0, 0);
    n_checks++;
    if (trigger_pos !== 24'd2 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_trigpos got pos=%0d done=%b exp pos=2 done=0",
               trigger_pos, done);
    end
    for (int j = 0; j < 5; j++) begin
      step(1, '0, 0, 0);
      n_checks++;
      if (wr_addr !== 24'(exp_a[j]) || done !== (j == 4) ||
          dut_st !== m_status()) begin
        n_fail++;
        $display("FAIL wrap_post[%0d] got addr=%0d done=%b exp addr=%0d done=%b",
                 j, wr_addr, done, exp_a[j], (j == 4));
      end
    end
  endtask

  task automatic test_edge_first();
    clear_cfg();
    c_ns = 1; c_mask[0] = 1; c_type[0] = 1; c_level[0] = 1;
    c_count[0] = 1; c_ptc = 2;
    apply_cfg();
    step(0, '0, 1, 0);
    step(1, 32'd1, 0, 0);
    n_checks++;
    if (triggered !== 1'b0 || dut_st !== m_status()) begin
      n_fail++;
      $display("FAIL edge_first got trig=%b exp 0", triggered);
    end
    step(1, 32'd0, 0, 0);
    step(1, 32'd1, 0, 0);
    n_checks++;
    if (triggered !== 1'b1 || trigger_pos !== 24'd2) begin
      n_fail++;
      $display("FAIL edge_second got trig=%b pos=%0d exp trig=1 pos=2",
               triggered, trigger_pos);
    end
  endtask

  task automatic test_abort_arm();
    n_checks++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre got armed=%b exp 1", armed);
    end
    step(0, '0, 1, 1);
    n_checks++;
    if (ready !== 1'b1 || triggered !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_arm got ready=%b trig=%b armed=%b exp 1 0 0",
               ready, triggered, armed);
    end
  endtask

  task automatic test_reset_mid();
    clear_cfg();
    c_ns = 2; c_ptc = 2;
    c_mask[0] = 1; c_type[0] = 1; c_level[0] = 1; c_count[0] = 1;
    c_mask[1] = 2; c_level[1] = 2; c_count[1] = 3;
    apply_cfg();
    step(0, '0, 1, 0);
    step(1, 32'd0, 0, 0);
    step(1, 32'd1, 0, 0);
    n_checks++;
    if (stage !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_pre got stage=%0d exp 1", stage);
    end
    #1 resetn = 0;
    #1;
    model_reset();
    n_checks++;
    if (stage !== 3'd0 || armed !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got stage=%0d armed=%b ready=%b exp 0 0 1",
               stage, armed, ready);
    end
    @(negedge clk);
    resetn = 1;
    step(1, 32'd1, 0, 0);
    n_checks++;
    if (dut_st !== m_status()) begin
      n_fail++;
      $display("FAIL mid_after got %h exp %h", dut_st, m_status());
    end
  endtask

  task automatic test_random();
    bit se, a, ab;
    logic [31:0] d;
    for (int r = 0; r < 12; r++) begin
      clear_cfg();
      c_ns = $urandom_range(0, 10);
      for (int k = 0; k < ST; k++) begin
        c_mask[k]  = $urandom_range(0, 15) & $urandom_range(0, 15);
        c_type[k]  = $urandom_range(0, 15);
        c_level[k] = $urandom_range(0, 15);
        c_count[k] = $urandom_range(0, 3);
      end
      c_ptc = $urandom_range(0, 6);
      c_bs  = $urandom_range(0, 7);
      apply_cfg();
      step(0, '0, 0, 1);
      step(0, '0, 1, 0);
      for (int i = 0; i < 80; i++) begin
        se = ($urandom_range(0, 3) != 0);
        d  = $urandom_range(0, 15);
        a  = ($urandom_range(0, 39) == 0);
        ab = ($urandom_range(0, 59) == 0);
        step(se, d, a, ab);
        n_checks++;
        if (dut_st !== m_status()) begin
          n_fail++;
          $display("FAIL random[%0d.%0d] got %h exp %h", r, i, dut_st,
                   m_status());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_level();
    test_two_stage();
    test_wrap_post();
    test_edge_first();
    test_abort_arm();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
